// File: rtl/demorgan_pkg.sv
// demorgan_pkg: shared state type, obs bit positions and golden De Morgan table
package demorgan_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  localparam int OBS_NOT_A  = 5;
  localparam int OBS_NOT_B  = 4;
  localparam int OBS_NAND   = 3;
  localparam int OBS_OR_N   = 2;
  localparam int OBS_NOR    = 1;
  localparam int OBS_AND_N  = 0;
  localparam logic [5:0] GOLDEN [4] = '{6'b111111, 6'b101100, 6'b011100, 6'b000000};
endpackage

// File: rtl/demorgan_golden.sv
// demorgan_golden: expected gate-block outputs for a given {a,b} vector
module demorgan_golden
  import demorgan_pkg::*;
(
  input  logic [1:0] i_vec,
  output logic [5:0] o_exp
);
  assign o_exp = GOLDEN[i_vec];
endmodule

// File: rtl/demorgan_checker.sv
// demorgan_checker: sweeps {a,b}, samples the gate block and grades it against the golden table
module demorgan_checker
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [5:0]       obs,
  output logic             busy,
  output logic             vec_valid,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [5:0]       first_fail_mask
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  state_t           r_state, w_next;
  logic [1:0]       r_vec;
  logic [PW-1:0]    r_pidx;
  logic [SW-1:0]    r_settle;
  logic [CNT_W-1:0] r_err, w_err_nxt;
  logic             r_pass, r_seen;
  logic [1:0]       r_ffv;
  logic [5:0]       r_ffm, w_exp, w_diff;
  logic             w_mis, w_last_pass, w_last;
  demorgan_golden u_golden (.i_vec(r_vec), .o_exp(w_exp));
  assign w_diff      = obs ^ w_exp;
  assign w_mis       = |w_diff;
  assign w_last_pass = r_pidx == PW'(PASSES - 1);
  assign w_last      = r_vec == 2'b11 && w_last_pass;
  assign w_err_nxt   = (w_mis && r_err != '1) ? r_err + 1'b1 : r_err;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // sequencing: one DRIVE, SETTLE_CYCLES of SETTLE, one SAMPLE per vector, then DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? DRIVE : IDLE;
      DRIVE:   w_next = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
      SETTLE:  w_next = r_settle == SW'(1) ? SAMPLE : SETTLE;
      SAMPLE:  w_next = w_last ? DONE : DRIVE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // counters and result registers; first failure is latched once per run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vec    <= '0;
      r_pidx   <= '0;
      r_settle <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
      r_seen   <= 1'b0;
      r_ffv    <= '0;
      r_ffm    <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_vec  <= '0;
          r_pidx <= '0;
          r_err  <= '0;
          r_pass <= 1'b0;
          r_seen <= 1'b0;
          r_ffv  <= '0;
          r_ffm  <= '0;
        end
        DRIVE:  r_settle <= SW'(SETTLE_CYCLES);
        SETTLE: r_settle <= r_settle - 1'b1;
        SAMPLE: begin
          r_err <= w_err_nxt;
          r_vec <= r_vec + 2'd1;
          if (w_mis && !r_seen) begin
            r_seen <= 1'b1;
            r_ffv  <= r_vec;
            r_ffm  <= w_diff;
          end
          if (r_vec == 2'b11 && !w_last_pass) r_pidx <= r_pidx + 1'b1;
          if (w_last) r_pass <= w_err_nxt == '0;
        end
        default: ;
      endcase
    end
  assign a               = (r_state == DRIVE || r_state == SETTLE || r_state == SAMPLE) & r_vec[1];
  assign b               = (r_state == DRIVE || r_state == SETTLE || r_state == SAMPLE) & r_vec[0];
  assign busy            = r_state != IDLE;
  assign vec_valid       = r_state == SAMPLE;
  assign done            = r_state == DONE;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_fail_vec  = r_ffv;
  assign first_fail_mask = r_ffm;
endmodule

// File: tb/tb_demorgan_checker.sv
// tb_demorgan_checker: scoreboard bench driving a modelled gate block with injectable faults
module tb_demorgan_checker;
  logic clk = 0, rst_n = 0, start1 = 0, start2 = 0, sel = 0;
  logic [5:0] and_m = '1, xor_m = '0;
  logic a1, b1, busy1, val1, done1, pass1, a2, b2, busy2, val2, done2, pass2;
  logic [3:0] err1;
  logic [1:0] err2, ffv1, ffv2, g_vec;
  logic [5:0] obs1, obs2, ffm1, ffm2, g_exp;
  logic m_a, m_b, m_busy, m_valid, m_done, m_pass;
  logic [3:0] m_err;
  logic [1:0] m_ffv;
  logic [5:0] m_ffm;
  int n_err = 0, n_chk = 0;
  logic [1:0] q [$];
  always #5 clk = ~clk;
  function automatic logic [5:0] gate(input logic x, input logic y);
    return {~x, ~y, ~(x & y), ~x | ~y, ~(x | y), ~x & ~y};
  endfunction
  assign obs1 = (gate(a1, b1) & and_m) ^ xor_m;
  assign obs2 = (gate(a2, b2) & and_m) ^ xor_m;
  demorgan_checker u1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .obs(obs1),
    .busy(busy1), .vec_valid(val1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_mask(ffm1));
  demorgan_checker #(.SETTLE_CYCLES(0), .PASSES(2), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n),
    .start(start2), .a(a2), .b(b2), .obs(obs2), .busy(busy2), .vec_valid(val2), .done(done2),
    .pass(pass2), .err_count(err2), .first_fail_vec(ffv2), .first_fail_mask(ffm2));
  demorgan_golden u_g (.i_vec(g_vec), .o_exp(g_exp));
  assign m_a     = sel ? a2 : a1;
  assign m_b     = sel ? b2 : b1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_valid = sel ? val2 : val1;
  assign m_done  = sel ? done2 : done1;
  assign m_pass  = sel ? pass2 : pass1;
  assign m_err   = sel ? {2'b00, err2} : err1;
  assign m_ffv   = sel ? ffv2 : ffv1;
  assign m_ffm   = sel ? ffm2 : ffm1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input bit s, input int passes, input int exp_cyc);
    int cyc, errs, cmax;
    logic [1:0] v, ffv;
    logic [5:0] msk, ffm;
    bit seen, got_done;
    sel = s;
    cmax = s ? 3 : 15;
    errs = 0; seen = 0; ffv = 0; ffm = 0; got_done = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 4; i++) q.push_back(2'(i));
    @(negedge clk);
    if (s) start2 = 1; else start1 = 1;
    @(posedge clk);
    cyc = 1;
    #1 start1 = 0; start2 = 0;
    while (!got_done && cyc < 200) begin
      @(negedge clk);
      if (m_valid) begin
        if (q.size() == 0) check("extra_sample", 1, 0);
        else begin
          v = q.pop_front();
          check("sample_vec", {m_a, m_b}, v);
          msk = ((gate(v[1], v[0]) & and_m) ^ xor_m) ^ gate(v[1], v[0]);
          if (msk != 0) begin
            if (!seen) begin seen = 1; ffv = v; ffm = msk; end
            if (errs < cmax) errs++;
          end
        end
      end
      if (m_done) begin
        got_done = 1;
        check("done_cycle", cyc, exp_cyc);
        check("busy_in_done", m_busy, 1);
        check("err_count", m_err, errs);
        check("pass", m_pass, errs == 0);
        check("first_fail_vec", m_ffv, ffv);
        check("first_fail_mask", m_ffm, ffm);
        check("samples_left", q.size(), 0);
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    q.delete();
    @(negedge clk);
    check("idle_after_done", {m_busy, m_done, m_a, m_b}, 0);
  endtask
  initial begin
    int dn;
    int dc [$];
    for (int i = 0; i < 4; i++) begin
      g_vec = 2'(i);
      #1 check("golden_table", g_exp, gate(g_vec[1], g_vec[0]));
    end
    repeat (2) @(negedge clk);
    check("reset_u1", {a1, b1, busy1, val1, done1, pass1, err1, ffv1, ffm1}, 0);
    check("reset_u2", {a2, b2, busy2, val2, done2, pass2, err2, ffv2, ffm2}, 0);
    rst_n = 1;
    run(0, 1, 13);
    and_m = ~6'b001000;
    run(0, 1, 13);
    and_m = '1; xor_m = '1;
    run(1, 2, 17);
    xor_m = '0;
    run(1, 2, 17);
    and_m = ~6'b001000;
    sel = 0;
    @(negedge clk);
    start1 = 1;
    @(posedge clk);
    #1 start1 = 0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pre_abort_err", m_err, 2);
    check("pre_abort_vec", {m_a, m_b, m_valid}, 3'b100);
    rst_n = 0;
    #1 check("abort_outputs", {m_a, m_b, m_busy, m_err, m_ffm, m_pass}, 0);
    @(negedge clk);
    rst_n = 1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_done) dn++;
    end
    check("abort_no_done", dn, 0);
    and_m = '1;
    run(0, 1, 13);
    @(negedge clk);
    start1 = 1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      if (c == 40) #1 start1 = 0;
      @(negedge clk);
      if (done1) dc.push_back(c);
    end
    check("hold_done_count", dc.size(), 3);
    for (int i = 0; i < 3 && i < dc.size(); i++) check("hold_done_cycle", dc[i], 13 + 14 * i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
